shifter24_up: RTL
=================

Name: shifter24_up

Overview:
- Gain-up stage for the MRFM 24-bit signed sample path. It is the transmit-direction counterpart of the right-shift/round/clip stage that reduces 50-bit accumulators to 24 bits.
- Arithmetically left-shifts each strobed 24-bit sample by a programmable amount (0..22) and saturates the result to 24 bits.
- Two-stage pipeline with strobe handshake.
- Counts saturation events for host readback.
- Sits between the sample source (loop filter/NCO mixer output) and the DAC formatter.

Parameters:
- WIDTH, 24, sample width in bits (in and out).
- SHIFT_MAX, 22, largest legal shift; larger codes are treated as 0.
- CNT_W, 16, width of the saturation event counter.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- strobe_in  in  1  one-cycle qualifier; in and shift are valid when high.
- in  in  WIDTH  signed two's-complement sample.
- shift  in  8  left-shift amount, sampled with strobe_in.
- clear  in  1  one-cycle pulse; clears sat_count and sat_sticky.
- strobe_out  out  1  one-cycle qualifier for out.
- out  out  WIDTH  shifted, saturated sample; holds between strobes.
- sat  out  1  high with strobe_out when that sample was clipped.
- sat_sticky  out  1  set by any clipped sample; cleared only by clear or reset.
- sat_count  out  CNT_W  number of clipped samples; saturates at all-ones (no wrap).

Behaviour:
- Reset (reset_n low, async): all pipeline registers, out, strobe_out, sat, sat_sticky and sat_count go to 0. The pipeline is flushed; an in-flight sample is discarded and produces no strobe_out.
- Stage 1, on strobe_in=1:
  - Register in.
  - Register shift_eff, where shift_eff = shift if shift <= SHIFT_MAX, else 0.
  - Set v1=1.
- Stage 1, on strobe_in=0: v1=0 and the data registers hold.
- Stage 2, on v1=1:
  - Form full = sign-extended in1 << shift_eff, width WIDTH+SHIFT_MAX (46) bits.
  - in_range = bits [45:23] of full are all 0 or all 1.
  - out = in_range ? full[23:0] : saturate(in1).
  - saturate(in1) = {in1[23], 23{~in1[23]}}, i.e. 0x7FFFFF for positive input and 0x800000 for negative input.
  - sat = ~in_range.
  - strobe_out = 1.
- Stage 2, on v1=0: strobe_out=0 and sat=0; out holds its last value.
- Latency: strobe_out is exactly 2 clocks after strobe_in. Throughput is one sample per clock; back-to-back strobes are legal.
- Zero input: never saturates, for any shift.
- shift=0: out=in, never saturates.
- Counter and flag:
  - Increment sat_count on strobe_out & sat, unless it is already all-ones.
  - Set sat_sticky on the same condition.
- Simultaneous clear and a saturating strobe_out: sat_count becomes 1 and sat_sticky becomes 1, so the event is not lost.
- clear with no event: sat_count=0, sat_sticky=0.
- shift changes mid-stream: each sample uses the shift sampled with its own strobe_in, so there is no glitch across the change.

Decomposition:
- Shared package mrfm24_pkg holds:
  - constants SAMPLE_W=24, SHIFT_W=8, SHIFT_MAX=22, CNT_W=16;
  - POS_FULL=0x7FFFFF and NEG_FULL=0x800000.
- One combinational sub-module, shl_sat24: inputs in and shift_eff; outputs out and sat. It contains the left shift, range check and clip.
- shifter24_up holds the stage registers, strobe pipeline, counter and sticky flag.

Test Plan:
- in=0x000001, shift=4, one strobe -> 2 clocks later strobe_out=1, out=0x000010, sat=0, sat_count=0.
- in=0x100000, shift=3 -> out=0x7FFFFF, sat=1, sat_count=1, sat_sticky=1. Then in=0x800000, shift=1 -> out=0x800000, sat=1, sat_count=2.
- in=0xFFFFFF (-1), shift=22 -> out=0xC00000, sat=0. Then shift=23 with in=0x123456 -> out=0x123456 (treated as shift 0), sat=0.
- Back-to-back strobes for 4 clocks with shifts 0,1,2,3 on in=0x000003 -> outs 0x000003, 0x000006, 0x00000C, 0x000018 on 4 consecutive clocks.
- Drive sat_count to 0xFFFF with repeated clipped samples, then one more -> stays 0xFFFF. Then assert clear in the same cycle as a clipped strobe_out -> sat_count=1, sat_sticky=1.
- Assert reset_n low between strobe_in and strobe_out -> no strobe_out, all outputs 0 immediately (async). After release, the first new sample emerges 2 clocks after its strobe_in.

Source files
------------

// File: rtl/mrfm24_pkg.sv
// Shared constants for the MRFM 24-bit signed sample path.
package mrfm24_pkg;

    localparam int SAMPLE_W  = 24;
    localparam int SHIFT_W   = 8;
    localparam int SHIFT_MAX = 22;
    localparam int CNT_W     = 16;

    localparam logic [SAMPLE_W-1:0] POS_FULL = 24'h7FFFFF;
    localparam logic [SAMPLE_W-1:0] NEG_FULL = 24'h800000;

endpackage

// File: rtl/shl_sat24.sv
// Combinational arithmetic left shift with saturation to WIDTH bits.
module shl_sat24
    import mrfm24_pkg::SAMPLE_W, mrfm24_pkg::SHIFT_W;
#(
    parameter int WIDTH     = SAMPLE_W,
    parameter int SHIFT_MAX = mrfm24_pkg::SHIFT_MAX
) (
    input  logic [WIDTH-1:0]   in,
    input  logic [SHIFT_W-1:0] shift_eff,
    output logic [WIDTH-1:0]   out,
    output logic               sat
);

    localparam int FW = WIDTH + SHIFT_MAX;

    logic [FW-1:0]    ext;
    logic [FW-1:0]    full;
    logic [SHIFT_MAX:0] top;
    logic             in_range;

    always_comb begin
        ext      = {{SHIFT_MAX{in[WIDTH-1]}}, in};
        full     = ext << shift_eff;
        // Result fits only when every bit above the output sign bit matches it.
        top      = full[FW-1:WIDTH-1];
        in_range = (&top) | ~(|top);
        out      = in_range ? full[WIDTH-1:0]
                            : {in[WIDTH-1], {(WIDTH-1){~in[WIDTH-1]}}};
        sat      = ~in_range;
    end

endmodule

// File: rtl/shifter24_up.sv
// Gain-up stage: two-stage strobed left shift with saturation and clip counter.
module shifter24_up
    import mrfm24_pkg::SAMPLE_W, mrfm24_pkg::SHIFT_W;
#(
    parameter int WIDTH     = SAMPLE_W,
    parameter int SHIFT_MAX = mrfm24_pkg::SHIFT_MAX,
    parameter int CNT_W     = mrfm24_pkg::CNT_W
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               strobe_in,
    input  logic [WIDTH-1:0]   in,
    input  logic [SHIFT_W-1:0] shift,
    input  logic               clear,
    output logic               strobe_out,
    output logic [WIDTH-1:0]   out,
    output logic               sat,
    output logic               sat_sticky,
    output logic [CNT_W-1:0]   sat_count
);

    logic               v1;
    logic [WIDTH-1:0]   in1;
    logic [SHIFT_W-1:0] sh1;
    logic [SHIFT_W-1:0] shift_eff;
    logic [WIDTH-1:0]   shl_out;
    logic               shl_sat;
    logic               sat_evt;

    always_comb begin
        shift_eff = (shift <= SHIFT_W'(SHIFT_MAX)) ? shift : '0;
        sat_evt   = strobe_out & sat;
    end

    shl_sat24 #(
        .WIDTH     (WIDTH),
        .SHIFT_MAX (SHIFT_MAX)
    ) u_shl (
        .in        (in1),
        .shift_eff (sh1),
        .out       (shl_out),
        .sat       (shl_sat)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v1         <= 1'b0;
            in1        <= '0;
            sh1        <= '0;
            strobe_out <= 1'b0;
            out        <= '0;
            sat        <= 1'b0;
        end else begin
            v1 <= strobe_in;
            if (strobe_in) begin
                in1 <= in;
                sh1 <= shift_eff;
            end
            strobe_out <= v1;
            sat        <= v1 & shl_sat;
            if (v1)
                out <= shl_out;
        end
    end

    // A clear coinciding with a clip restarts the count at 1 so the event is kept.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sat_count  <= '0;
            sat_sticky <= 1'b0;
        end else if (clear) begin
            sat_count  <= sat_evt ? CNT_W'(1) : '0;
            sat_sticky <= sat_evt;
        end else if (sat_evt) begin
            if (sat_count != '1)
                sat_count <= sat_count + CNT_W'(1);
            sat_sticky <= 1'b1;
        end
    end

endmodule
